// File: rtl/keypad_pkg.sv
// Shared types, constants and decode helpers for the 4x4 keypad scanner.
// Row r / column c index the matrix; both pins are active-low.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  // Index of the single low bit in a one-cold column vector.
  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!col[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Returns {hit, key}. Only a single low row is a valid press; none or
  // several low rows (ghosting) decode as no key.
  function automatic logic [4:0] decode_row(input logic [3:0] row,
                                            input logic [1:0] col);
    logic [4:0] res;
    int         lows;
    res  = 5'd0;
    lows = 0;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) begin
        lows = lows + 1;
        res  = {1'b1, KEY_MAP[2'(r)][col]};
      end
    end
    if (lows != 1) res = 5'd0;
    return res;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row inputs.
// Resets to all ones so an idle matrix reads as "no row pressed".
module keypad_row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/keypad_scan_decoder.sv
// Column-scanning 4x4 keypad decoder with press/release debouncing.
// Drives one-cold columns, parks on a detected key and reports a level-valid hex code.
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic [3:0] digit,
  output logic       valid
);

  localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST   = DWELL_W'(SCAN_DIV - 1);
  localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(DEBOUNCE_SCANS);

  state_t               state_q, state_d;
  logic [3:0]           col_q, col_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [3:0]           cand_q, cand_d;
  logic [3:0]           digit_q, digit_d;
  logic                 valid_q, valid_d;

  logic [3:0]           row_s;
  logic [4:0]           decoded;
  logic                 sample_en;
  logic                 hit;
  logic [3:0]           key;
  logic                 same_key;
  logic [MATCH_W-1:0]   match_inc;

  keypad_row_sync #(
    .WIDTH (4)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .din   (row),
    .dout  (row_s)
  );

  assign sample_en = (dwell_q == DWELL_LAST);
  assign decoded   = decode_row(row_s, col_index(col_q));
  assign hit       = decoded[4];
  assign key       = decoded[3:0];
  assign same_key  = hit && (key == cand_q);
  assign match_inc = match_q + 1'b1;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    match_d = match_q;
    cand_d  = cand_q;
    digit_d = digit_q;
    valid_d = valid_q;
    dwell_d = sample_en ? '0 : dwell_q + 1'b1;

    // Rows only matter on the last dwell cycle of each column; the column
    // rotates solely from SCAN with nothing seen, so any candidate or held
    // key keeps it parked and rotation resumes at the next column after.
    if (sample_en) begin
      unique case (state_q)
        SCAN: begin
          if (hit) begin
            cand_d  = key;
            match_d = MATCH_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_d = HELD;
              valid_d = 1'b1;
              digit_d = key;
              match_d = '0;
            end else begin
              state_d = CONFIRM;
            end
          end else begin
            col_d = {col_q[2:0], col_q[3]};
          end
        end

        CONFIRM: begin
          if (same_key) begin
            if (match_inc == MATCH_TARGET) begin
              state_d = HELD;
              valid_d = 1'b1;
              digit_d = cand_q;
              match_d = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            state_d = SCAN;
            match_d = '0;
          end
        end

        HELD: begin
          // A different key is treated as a release, never a direct handover.
          if (same_key) begin
            match_d = '0;
          end else if (match_inc == MATCH_TARGET) begin
            state_d = SCAN;
            valid_d = 1'b0;
            digit_d = 4'h0;
            match_d = '0;
          end else begin
            match_d = match_inc;
          end
        end

        default: begin
          state_d = SCAN;
          match_d = '0;
          valid_d = 1'b0;
          digit_d = 4'h0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= COL_RESET;
      dwell_q <= '0;
      match_q <= '0;
      cand_q  <= 4'h0;
      digit_q <= 4'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      dwell_q <= dwell_d;
      match_q <= match_d;
      cand_q  <= cand_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
    end
  end

  assign column = col_q;
  assign digit  = digit_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Bench for keypad_scan_decoder: a simulated keypad answers the driven column,
// and a sample-level reference model predicts column, digit and valid every cycle.
module tb_keypad_scan_decoder;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row = 4'hF;
  logic [3:0] column;
  logic [3:0] digit;
  logic       valid;

  int checks = 0;
  int errors = 0;

  // Simulated keypad: rows pulled low only while press_c is the driven column.
  int         press_c    = -1;
  logic [3:0] press_rows = 4'hF;

  // Reference model, expressed in samples and key identities.
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int m_tick, m_col, m_cand, m_streak, m_held, m_rel;
  logic [3:0] m_s1, m_s2;

  always #5 clk = ~clk;

  keypad_scan_decoder #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .row    (row),
    .column (column),
    .digit  (digit),
    .valid  (valid)
  );

  function automatic int m_lookup(input logic [3:0] rows, input int c);
    if ($countones(~rows) != 1) return -1;
    for (int r = 0; r < 4; r++) if (!rows[r]) return keymap[r*4 + c];
    return -1;
  endfunction

  function automatic logic [3:0] m_column();
    logic [3:0] v;
    v = 4'hF;
    v[m_col] = 1'b0;
    return v;
  endfunction

  function automatic logic m_valid();
    return m_held >= 0;
  endfunction

  function automatic logic [3:0] m_digit();
    return (m_held >= 0) ? 4'(m_held) : 4'h0;
  endfunction

  task automatic model_reset();
    m_tick = 0; m_col = 0; m_cand = -1; m_streak = 0; m_held = -1; m_rel = 0;
    m_s1 = 4'hF; m_s2 = 4'hF;
  endtask

  task automatic model_edge();
    int k;
    if (m_tick == SCAN_DIV - 1) begin
      k = m_lookup(m_s2, m_col);
      if (m_held >= 0) begin
        if (k == m_held) m_rel = 0;
        else begin
          m_rel++;
          if (m_rel == DEB) begin m_held = -1; m_rel = 0; end
        end
      end else if (m_cand >= 0) begin
        if (k == m_cand) begin
          m_streak++;
          if (m_streak == DEB) begin m_held = m_cand; m_cand = -1; m_rel = 0; end
        end else m_cand = -1;
      end else if (k >= 0) begin
        m_cand = k; m_streak = 1;
        if (DEB == 1) begin m_held = k; m_cand = -1; m_rel = 0; end
      end else begin
        m_col = (m_col + 1) % 4;
      end
    end
    m_s2 = m_s1;
    m_s1 = row;
    m_tick = (m_tick + 1) % SCAN_DIV;
  endtask

  // One clock: keypad responds at the falling edge, model steps at the rising edge.
  task automatic cycle();
    @(negedge clk);
    row = (press_c >= 0 && column[press_c] == 1'b0) ? press_rows : 4'hF;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    press_c = -1; row = 4'hF; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (column !== 4'b1110) begin errors++; $display("FAIL reset_column: got %b want %b", column, 4'b1110); end
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (digit !== 4'h0) begin errors++; $display("FAIL reset_digit: got %h want 0", digit); end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_idle_scan();
    for (int n = 0; n < 24; n++) begin
      cycle();
      checks += 3;
      if (column !== m_column()) begin errors++; $display("FAIL idle_column: got %b want %b", column, m_column()); end
      if (valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", valid); end
      if (digit !== 4'h0) begin errors++; $display("FAIL idle_digit: got %h want 0", digit); end
    end
  endtask

  task automatic test_press_release();
    int n;
    press_c = 1; press_rows = 4'b1101;
    for (n = 0; n < 200; n++) begin
      cycle();
      checks += 3;
      if (column !== m_column()) begin errors++; $display("FAIL press_column: got %b want %b", column, m_column()); end
      if (valid !== m_valid()) begin errors++; $display("FAIL press_valid: got %b want %b", valid, m_valid()); end
      if (digit !== m_digit()) begin errors++; $display("FAIL press_digit: got %h want %h", digit, m_digit()); end
      if (m_held >= 0) break;
    end
    checks += 3;
    if (n >= 200) begin errors++; $display("FAIL press_timeout: got no accept want accept within 200 cycles"); end
    if (digit !== 4'h5) begin errors++; $display("FAIL press_key5: got %h want 5", digit); end
    if (column !== 4'b1101) begin errors++; $display("FAIL press_parked: got %b want 1101", column); end
    repeat (20) begin
      cycle();
      checks += 2;
      if (column !== 4'b1101) begin errors++; $display("FAIL hold_parked: got %b want 1101", column); end
      if (valid !== 1'b1 || digit !== 4'h5) begin errors++; $display("FAIL hold_output: got %b/%h want 1/5", valid, digit); end
    end
    press_c = -1;
    for (n = 0; n < 200; n++) begin
      cycle();
      checks += 3;
      if (column !== m_column()) begin errors++; $display("FAIL release_column: got %b want %b", column, m_column()); end
      if (valid !== m_valid()) begin errors++; $display("FAIL release_valid: got %b want %b", valid, m_valid()); end
      if (digit !== m_digit()) begin errors++; $display("FAIL release_digit: got %h want %h", digit, m_digit()); end
      if (column !== 4'b1101) break;
    end
    checks += 2;
    if (column !== 4'b1011) begin errors++; $display("FAIL release_next_col: got %b want 1011", column); end
    if (valid !== 1'b0 || digit !== 4'h0) begin errors++; $display("FAIL release_output: got %b/%h want 0/0", valid, digit); end
  endtask

  task automatic test_bounce();
    int n;
    logic saw_valid, saw_move;
    saw_valid = 1'b0; saw_move = 1'b0;
    press_c = 1; press_rows = 4'b1101;
    for (n = 0; n < 200 && m_cand < 0; n++) begin
      cycle();
      checks += 1;
      if (column !== m_column()) begin errors++; $display("FAIL bounce_column: got %b want %b", column, m_column()); end
    end
    press_c = -1;
    for (n = 0; n < 48; n++) begin
      cycle();
      if (valid) saw_valid = 1'b1;
      if (column !== 4'b1101) saw_move = 1'b1;
      checks += 1;
      if (column !== m_column()) begin errors++; $display("FAIL bounce_column: got %b want %b", column, m_column()); end
    end
    checks += 2;
    if (saw_valid !== 1'b0) begin errors++; $display("FAIL bounce_valid: got valid high want never"); end
    if (saw_move !== 1'b1) begin errors++; $display("FAIL bounce_rotate: got parked want rotation"); end
  endtask

  task automatic test_multi();
    int n;
    logic saw_valid;
    press_c = 3; press_rows = 4'b0111;
    for (n = 0; n < 200 && !m_valid(); n++) begin
      cycle();
      checks += 2;
      if (column !== m_column()) begin errors++; $display("FAIL keyd_column: got %b want %b", column, m_column()); end
      if (valid !== m_valid()) begin errors++; $display("FAIL keyd_valid: got %b want %b", valid, m_valid()); end
    end
    checks += 2;
    if (valid !== 1'b1) begin errors++; $display("FAIL keyd_accept: got %b want 1", valid); end
    if (digit !== 4'hD) begin errors++; $display("FAIL keyd_digit: got %h want d", digit); end
    press_c = -1;
    for (n = 0; n < 200 && m_valid(); n++) begin
      cycle();
      checks += 1;
      if (valid !== m_valid()) begin errors++; $display("FAIL keyd_release: got %b want %b", valid, m_valid()); end
    end
    saw_valid = 1'b0;
    press_c = 3; press_rows = 4'b0011;
    for (n = 0; n < 60; n++) begin
      cycle();
      if (valid) saw_valid = 1'b1;
      checks += 1;
      if (column !== m_column()) begin errors++; $display("FAIL ghost_column: got %b want %b", column, m_column()); end
    end
    checks += 1;
    if (saw_valid !== 1'b0) begin errors++; $display("FAIL ghost_valid: got valid high want never"); end
    press_c = -1;
    repeat (8) cycle();
  endtask

  task automatic test_async_reset();
    int n;
    press_c = 2; press_rows = 4'b1011;
    for (n = 0; n < 200 && !m_valid(); n++) begin
      cycle();
      checks += 2;
      if (valid !== m_valid()) begin errors++; $display("FAIL r2c2_valid: got %b want %b", valid, m_valid()); end
      if (digit !== m_digit()) begin errors++; $display("FAIL r2c2_digit: got %h want %h", digit, m_digit()); end
    end
    checks += 1;
    if (valid !== 1'b1) begin errors++; $display("FAIL r2c2_accept: got %b want 1", valid); end
    #2 reset = 1'b1;
    #1;
    checks += 3;
    if (column !== 4'b1110) begin errors++; $display("FAIL async_column: got %b want 1110", column); end
    if (valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", valid); end
    if (digit !== 4'h0) begin errors++; $display("FAIL async_digit: got %h want 0", digit); end
    press_c = -1; row = 4'hF;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_key_switch();
    int n;
    logic saw_low, done;
    press_c = 0; press_rows = 4'b1110;
    for (n = 0; n < 200 && !m_valid(); n++) begin
      cycle();
      checks += 1;
      if (valid !== m_valid()) begin errors++; $display("FAIL key1_valid: got %b want %b", valid, m_valid()); end
    end
    checks += 1;
    if (digit !== 4'h1) begin errors++; $display("FAIL key1_digit: got %h want 1", digit); end
    press_rows = 4'b1101;
    saw_low = 1'b0; done = 1'b0;
    for (n = 0; n < 400 && !done; n++) begin
      cycle();
      checks += 3;
      if (column !== m_column()) begin errors++; $display("FAIL switch_column: got %b want %b", column, m_column()); end
      if (valid !== m_valid()) begin errors++; $display("FAIL switch_valid: got %b want %b", valid, m_valid()); end
      if (digit !== m_digit()) begin errors++; $display("FAIL switch_digit: got %h want %h", digit, m_digit()); end
      if (!valid) saw_low = 1'b1;
      if (saw_low && valid) done = 1'b1;
    end
    checks += 2;
    if (saw_low !== 1'b1) begin errors++; $display("FAIL switch_gap: got no low gap want valid low between keys"); end
    if (digit !== 4'h4) begin errors++; $display("FAIL switch_key4: got %h want 4", digit); end
    press_c = -1;
    repeat (40) cycle();
  endtask

  task automatic test_random();
    int hold, rest, r;
    for (int it = 0; it < 12; it++) begin
      press_c = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      press_rows = 4'hF;
      press_rows[r] = 1'b0;
      if ($urandom_range(0, 3) == 0) press_rows[(r + 1) % 4] = 1'b0;
      hold = $urandom_range(2, 140);
      rest = $urandom_range(2, 80);
      for (int n = 0; n < hold + rest; n++) begin
        if (n == hold) press_c = -1;
        cycle();
        checks += 3;
        if (column !== m_column()) begin errors++; $display("FAIL rand_column: got %b want %b", column, m_column()); end
        if (valid !== m_valid()) begin errors++; $display("FAIL rand_valid: got %b want %b", valid, m_valid()); end
        if (digit !== m_digit()) begin errors++; $display("FAIL rand_digit: got %h want %h", digit, m_digit()); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_scan();
    test_press_release();
    test_bounce();
    test_multi();
    test_async_reset();
    test_key_switch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
